// File: rtl/dlfloat_pkg.sv
// dlfloat_pkg: shared DLFloat16 constants and sequencer state encoding.
package dlfloat_pkg;
   localparam int DLF_W = 16;
   typedef logic [DLF_W-1:0] dlf_t;
   localparam dlf_t DLF_ZERO = 16'h0000;
   localparam dlf_t DLF_ONE  = 16'h3E00;
   typedef enum logic [2:0] {S_IDLE, S_CLR, S_LOAD, S_DRAIN, S_DONE} state_t;
endpackage

// File: rtl/dlfloat_dot_seq_if.sv
// dlfloat_dot_seq_if: operand stream, MAC drive and result port of the dot-product sequencer.
interface dlfloat_dot_seq_if import dlfloat_pkg::*; #(parameter int LEN_W = 8);
   logic             start, abort, in_valid, in_ready;
   logic             mac_clr, mac_acc_en, busy, res_valid, res_ready;
   logic [LEN_W-1:0] cfg_len;
   dlf_t             in_a, in_b, mac_a, mac_b, mac_c, res_data;
   modport master (
      output start, abort, cfg_len, in_valid, in_a, in_b, mac_c, res_ready,
      input  in_ready, mac_a, mac_b, mac_clr, mac_acc_en, busy, res_valid, res_data
   );
   modport slave (
      input  start, abort, cfg_len, in_valid, in_a, in_b, mac_c, res_ready,
      output in_ready, mac_a, mac_b, mac_clr, mac_acc_en, busy, res_valid, res_data
   );
endinterface

// File: rtl/dlfloat_vld_pipe.sv
// dlfloat_vld_pipe: valid delay line of DEPTH stages with synchronous flush.
module dlfloat_vld_pipe #(parameter int DEPTH = 2) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_flush,
   input  logic i_vld,
   output logic o_vld
);
   logic [DEPTH-1:0] r_sr;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_sr <= '0;
      else r_sr <= i_flush ? '0 : DEPTH'({r_sr, i_vld});
   end
   assign o_vld = r_sr[DEPTH-1];
endmodule

// File: rtl/dlfloat_dot_seq.sv
// dlfloat_dot_seq: clears the MAC, streams LEN operand pairs into it, drains the
// pipeline and returns the accumulated DLFloat16 sum on a valid/ready port.
module dlfloat_dot_seq import dlfloat_pkg::*; #(
   parameter int LEN_W    = 8,
   parameter int PIPE_LAT = 1
) (
   input logic              clk,
   input logic              rst_n,
   dlfloat_dot_seq_if.slave bus
);
   localparam int DW = $clog2(PIPE_LAT + 2);
   state_t           r_state;
   logic [LEN_W-1:0] r_rem;
   logic [DW-1:0]    r_drain;
   logic             r_in_ready, r_clr, r_busy, r_res_valid;
   dlf_t             r_mac_a, r_mac_b, r_res_data;
   logic             w_abort, w_fire, w_acc_en;
   assign w_abort = bus.abort & (r_state inside {S_CLR, S_LOAD, S_DRAIN});
   // an abort in the same cycle as a fire cancels that pair too
   assign w_fire  = bus.in_valid & r_in_ready & ~w_abort;
   dlfloat_vld_pipe #(.DEPTH(PIPE_LAT + 1)) u_pipe (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_flush(w_abort),
      .i_vld  (w_fire),
      .o_vld  (w_acc_en)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_rem       <= '0;
         r_drain     <= '0;
         r_in_ready  <= 1'b0;
         r_clr       <= 1'b0;
         r_busy      <= 1'b0;
         r_res_valid <= 1'b0;
         r_mac_a     <= DLF_ZERO;
         r_mac_b     <= DLF_ZERO;
         r_res_data  <= DLF_ZERO;
      end else begin
         r_mac_a <= w_fire ? bus.in_a : DLF_ZERO;
         r_mac_b <= w_fire ? bus.in_b : DLF_ZERO;
         r_clr   <= 1'b0;
         if (w_abort) begin
            r_state    <= S_IDLE;
            r_rem      <= '0;
            r_drain    <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: if (bus.start) begin
                  r_rem   <= bus.cfg_len;
                  r_clr   <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= S_CLR;
               end
               S_CLR: begin
                  r_in_ready <= r_rem != '0;
                  r_state    <= (r_rem == '0) ? S_DRAIN : S_LOAD;
               end
               S_LOAD: if (w_fire) begin
                  r_rem <= r_rem - LEN_W'(1);
                  if (r_rem == LEN_W'(1)) begin
                     r_in_ready <= 1'b0;
                     r_drain    <= DW'(PIPE_LAT + 1);
                     r_state    <= S_DRAIN;
                  end
               end
               S_DRAIN: begin
                  if (r_drain == '0) begin
                     r_res_data  <= bus.mac_c;
                     r_res_valid <= 1'b1;
                     r_state     <= S_DONE;
                  end else r_drain <= r_drain - DW'(1);
               end
               S_DONE: if (bus.res_ready) begin
                  r_res_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end
   assign bus.in_ready   = r_in_ready;
   assign bus.mac_a      = r_mac_a;
   assign bus.mac_b      = r_mac_b;
   assign bus.mac_clr    = r_clr;
   assign bus.mac_acc_en = w_acc_en;
   assign bus.busy       = r_busy;
   assign bus.res_valid  = r_res_valid;
   assign bus.res_data   = r_res_data;
endmodule

// File: tb/tb_dlfloat_dot_seq.sv
// tb_dlfloat_dot_seq: dot-product sequencer driving a behavioural DLFloat16 MAC,
// checked every cycle against a timestamp-based model of the job rules.
module tb_dlfloat_dot_seq;
   import dlfloat_pkg::*;
   localparam int LEN_W = 8, PIPE_LAT = 1;
   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;
   dlfloat_dot_seq_if #(.LEN_W(LEN_W)) bus();
   dlfloat_dot_seq #(.LEN_W(LEN_W), .PIPE_LAT(PIPE_LAT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   int total = 0, bad = 0;
   dlf_t pa[8], pb[8];
   dlf_t vals[6] = '{16'h0000, 16'h3E00, 16'h4000, 16'h3C00, 16'hBE00, 16'h3F00};

   function automatic real dlf2r(dlf_t v);
      real m;
      int  e;
      if (v[14:9] == 6'd0) return 0.0;
      m = 1.0 + real'(v[8:0]) / 512.0;
      e = int'(v[14:9]) - 31;
      while (e > 0) begin m = m * 2.0; e--; end
      while (e < 0) begin m = m / 2.0; e++; end
      return v[15] ? -m : m;
   endfunction

   function automatic dlf_t r2dlf(real x);
      real  m;
      int   e;
      logic s;
      if (x == 0.0) return DLF_ZERO;
      s = x < 0.0;
      m = s ? -x : x;
      e = 31;
      while (m >= 2.0) begin m = m / 2.0; e++; end
      while (m < 1.0) begin m = m * 2.0; e--; end
      return {s, 6'(e), 9'($rtoi((m - 1.0) * 512.0))};
   endfunction

   // behavioural MAC: one product register feeding the accumulator
   real prod = 0.0, acc = 0.0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod <= 0.0;
         acc  <= 0.0;
      end else begin
         prod <= dlf2r(bus.mac_a) * dlf2r(bus.mac_b);
         acc  <= bus.mac_clr ? 0.0 : (bus.mac_acc_en ? acc + prod : acc);
      end
   end
   assign bus.mac_c = r2dlf(acc);

   // reference: job rules expressed as edge timestamps and the running dot product
   logic e_ready = 0, e_clr = 0, e_en = 0, e_busy = 0, e_valid = 0;
   dlf_t e_a = '0, e_b = '0, e_data = '0;
   int   t = 0, rem = 0, load_t = -1, cap_t = -1;
   real  sum = 0.0;
   int   fires[$];
   logic m_fire, m_busy0, m_done0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {e_ready, e_clr, e_en, e_busy, e_valid} = '0;
         e_a = '0; e_b = '0; e_data = '0;
         load_t = -1; cap_t = -1; rem = 0;
         fires.delete();
      end else begin
         t++;
         m_fire  = e_ready & bus.in_valid;
         m_busy0 = e_busy;
         m_done0 = e_valid;
         e_clr   = 1'b0;
         if (bus.abort && m_busy0 && !m_done0) begin
            e_busy = 0; e_ready = 0; load_t = -1; cap_t = -1;
            e_a = '0; e_b = '0;
            fires.delete();
         end else begin
            e_a = m_fire ? bus.in_a : '0;
            e_b = m_fire ? bus.in_b : '0;
            if (m_fire) begin
               fires.push_back(t);
               sum = sum + dlf2r(bus.in_a) * dlf2r(bus.in_b);
               rem--;
               if (rem == 0) begin e_ready = 0; cap_t = t + PIPE_LAT + 2; end
            end
            if (!m_busy0 && bus.start) begin
               e_busy = 1; e_clr = 1; sum = 0.0;
               rem = int'(bus.cfg_len);
               if (rem == 0) cap_t = t + 2;
               else load_t = t + 1;
            end
            if (t == load_t) e_ready = 1;
            if (t == cap_t) begin e_valid = 1; e_data = r2dlf(sum); end
            if (m_done0 && bus.res_ready) begin e_valid = 0; e_busy = 0; end
         end
         while (fires.size() > 0 && fires[0] + PIPE_LAT < t) void'(fires.pop_front());
         e_en = (fires.size() > 0) && (fires[0] + PIPE_LAT == t);
      end
   end

   task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0d got=%h exp=%h", n, t, act, exp);
      end
   endtask

   always @(negedge clk) begin
      chk("in_ready", 16'(bus.in_ready), 16'(e_ready));
      chk("mac_a", bus.mac_a, e_a);
      chk("mac_b", bus.mac_b, e_b);
      chk("mac_clr", 16'(bus.mac_clr), 16'(e_clr));
      chk("mac_acc_en", 16'(bus.mac_acc_en), 16'(e_en));
      chk("busy", 16'(bus.busy), 16'(e_busy));
      chk("res_valid", 16'(bus.res_valid), 16'(e_valid));
      chk("res_data", bus.res_data, e_data);
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic job(input int len, input int gap, input int hold, input int ab,
                      input bit rst_mid, input logic [15:0] exp);
      int n = 0, g = 0, k, guard = 0;
      bit f;
      bus.cfg_len = LEN_W'(len);
      bus.start   = 1'b1;
      step();
      bus.start = 1'b0;
      k = t;
      while (n < len && guard < 100) begin
         guard++;
         if (g > 0) begin bus.in_valid = 1'b0; g--; end
         else begin bus.in_valid = 1'b1; bus.in_a = pa[n]; bus.in_b = pb[n]; end
         f = bus.in_valid && bus.in_ready;
         step();
         if (f) begin n++; g = gap; k = t; end
         if (ab != 0 && n == ab) begin
            bus.in_valid = 1'b0;
            bus.abort    = 1'b1;
            step();
            bus.abort = 1'b0;
            chk("abort_busy", 16'(bus.busy), 16'h0);
            chk("abort_acc_en", 16'(bus.mac_acc_en), 16'h0);
            repeat (6) begin step(); chk("abort_nores", 16'(bus.res_valid), 16'h0); end
            return;
         end
      end
      bus.in_valid = 1'b0;
      chk("fed", 16'(n), 16'(len));
      if (rst_mid) begin
         step();
         rst_n = 1'b0;
         step();
         chk("rst_busy", 16'(bus.busy), 16'h0);
         chk("rst_acc_en", 16'(bus.mac_acc_en), 16'h0);
         chk("rst_data", bus.res_data, 16'h0);
         rst_n = 1'b1;
         step();
         return;
      end
      guard = 0;
      while (!bus.res_valid && guard < 50) begin step(); guard++; end
      chk("res_timeout", 16'(bus.res_valid), 16'h1);
      chk("latency", 16'(t - k), 16'(len == 0 ? 2 : PIPE_LAT + 2));
      chk("result", bus.res_data, exp);
      for (int i = 0; i < hold; i++) begin
         bus.start = (i == 1);
         step();
         chk("hold_valid", 16'(bus.res_valid), 16'h1);
         chk("hold_data", bus.res_data, exp);
         chk("hold_busy", 16'(bus.busy), 16'h1);
      end
      bus.res_ready = 1'b1;
      bus.start     = hold > 0;
      step();
      bus.res_ready = 1'b0;
      bus.start     = 1'b0;
      chk("hs_valid", 16'(bus.res_valid), 16'h0);
      step();
      chk("idle_busy", 16'(bus.busy), 16'h0);
   endtask

   initial begin
      bus.start = 0; bus.abort = 0; bus.cfg_len = '0; bus.in_valid = 0;
      bus.in_a = '0; bus.in_b = '0; bus.res_ready = 0;
      step();
      step();
      chk("rst_busy0", 16'(bus.busy), 16'h0);
      chk("rst_ready0", 16'(bus.in_ready), 16'h0);
      chk("rst_valid0", 16'(bus.res_valid), 16'h0);
      rst_n = 1'b1;
      step();
      pa[0] = 16'h3E00; pb[0] = 16'h3E00;
      job(1, 0, 0, 0, 0, 16'h3E00);
      for (int i = 0; i < 3; i++) begin pa[i] = 16'h4000; pb[i] = 16'h3E00; end
      job(3, 0, 0, 0, 0, 16'h4300);
      for (int i = 0; i < 2; i++) begin pa[i] = 16'h3E00; pb[i] = 16'h3E00; end
      job(2, 3, 0, 0, 0, 16'h4000);
      pa[0] = 16'h3F00; pb[0] = 16'h4000;
      job(1, 0, 5, 0, 0, 16'h4100);
      for (int i = 0; i < 3; i++) begin pa[i] = 16'h3E00; pb[i] = 16'h3E00; end
      job(3, 0, 0, 2, 0, 16'h0000);
      job(1, 0, 0, 0, 0, 16'h3E00);
      job(2, 0, 0, 0, 1, 16'h0000);
      job(0, 0, 0, 0, 0, 16'h0000);
      for (int i = 0; i < 3000; i++) begin
         bus.start     = $urandom_range(0, 9) == 0;
         bus.cfg_len   = LEN_W'($urandom_range(0, 5));
         bus.in_valid  = $urandom_range(0, 9) < 6;
         bus.in_a      = vals[$urandom_range(0, 5)];
         bus.in_b      = vals[$urandom_range(0, 5)];
         bus.abort     = $urandom_range(0, 39) == 0;
         bus.res_ready = $urandom_range(0, 1) == 1;
         if (i == 1500) rst_n = 1'b0;
         if (i == 1503) rst_n = 1'b1;
         step();
      end
      bus.start = 0; bus.abort = 0; bus.in_valid = 0; bus.res_ready = 1;
      repeat (10) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
